receiver_sample_framer: RTL
===========================

RECEIVER_SAMPLE_FRAMER -- requirements
Module: receiver_sample_framer

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter SAMPLE_RATE_HZ, default 200_000, ADC conversion rate; TICK_PERIOD = CLK_FREQ_HZ/SAMPLE_RATE_HZ (500).
REQ-003 SHALL have parameter FRAME_LEN, default 2048, samples per FFT frame (power of two).
REQ-004 SHALL have parameter DC_SHIFT, default 8, DC-tracker IIR shift.
REQ-005 SHALL have ports: clk_in  in  1  sole clock, rising edge; one clock only.
REQ-006 rst_n_in  in  1  reset, asynchronous assert, active-low.
REQ-007 enable_in  in  1  level; start/continue framing.
REQ-008 adc_req_out  out  1  one-cycle conversion-start pulse.
REQ-009 adc_data_in  in  12  unsigned ADC code, midscale 2048.
REQ-010 adc_valid_in  in  1  one-cycle pulse, adc_data_in valid.
REQ-011 sample_out  out  16  signed, DC-corrected sample to velocity stage receiver_data.
REQ-012 sample_valid_out  out  1  one-cycle pulse, drives velocity stage receiver_data_valid_in.
REQ-013 frame_start_out  out  1  pulses with sample index 0.
REQ-014 frame_done_out  out  1  pulses with sample index FRAME_LEN-1.
REQ-015 miss_out  out  1  sticky; an ADC result was not returned in time.

Function
REQ-016 Tick counter SHALL count 0..TICK_PERIOD-1 continuously while not IDLE; tick at count 0.
REQ-017 FSM states SHALL be IDLE, WAIT_ADC, HOLD; IDLE->WAIT_ADC on tick with enable_in=1, asserting adc_req_out that cycle.
REQ-018 WAIT_ADC: adc_valid_in=1 SHALL capture data, go HOLD; sample_valid_out asserts exactly one cycle later (latency 1).
REQ-019 WAIT_ADC: next tick arriving without adc_valid_in SHALL set miss_out, re-emit previous sample_out with sample_valid_out, issue new adc_req_out, stay WAIT_ADC.
REQ-020 HOLD: adc_valid_in SHALL be ignored; next tick SHALL issue adc_req_out and go WAIT_ADC.
REQ-021 adc_valid_in coincident with tick in WAIT_ADC SHALL be accepted (no miss) and the new request issued same cycle.
REQ-022 Conversion: x = (adc_data_in - 2048) << 3, signed 16-bit, range -16384..16376.
REQ-023 Output SHALL be x - dc, saturated to -32768..32767.
REQ-024 Sample index SHALL count 0..FRAME_LEN-1 per emitted sample, wrapping to 0; frame pulses coincide with sample_valid_out.
REQ-025 enable_in deasserted mid-frame SHALL finish the current frame, then enter IDLE after frame_done_out; partial frames never emitted.
REQ-026 enable_in reasserted in IDLE SHALL start at index 0 with frame_start_out.

Reset
REQ-027 rst_n_in low SHALL asynchronously force IDLE, counters 0, dc 0, sample_out 0, all pulses 0, miss_out 0.
REQ-028 Reset mid-frame SHALL discard the partial frame; restart begins at index 0.
REQ-029 Release SHALL be synchronized internally; first tick no earlier than 2 cycles after release.

Configuration
REQ-030 Macro DC_REMOVE_EN defined: dc tracker dc += (x - dc) >>> DC_SHIFT per accepted sample, 24-bit accumulator with 8 fractional bits.
REQ-031 DC_REMOVE_EN undefined: dc constant 0, sample_out = x, tracker logic absent.

Structure
REQ-032 Shared package sonic_pkg SHALL hold FSM state enum, ADC_MIDSCALE=2048, ADC_WIDTH=12, SAMPLE_WIDTH=16.
REQ-033 DC tracking and saturation SHALL be sub-module dc_blocker; tick/FSM/index in top.

Verification
REQ-034 ADC model replies 10 cycles after each request, code 2048 constant, DC_REMOVE_EN off -> 2048 samples all 0, frame_start at 1st, frame_done at 2048th, period 500 cycles.
REQ-035 Code 4095 constant, DC_REMOVE_EN on -> first sample 16376, decays monotonically toward 0, below 64 after 4096 samples.
REQ-036 ADC silent for one request -> miss_out=1, previous sample repeated, index still advances by 1.
REQ-037 enable_in dropped at index 100 -> samples continue to index 2047, frame_done, then no adc_req_out.
REQ-038 rst_n_in low at index 500 for 3 cycles -> outputs 0 immediately; after release next frame_start with index 0.
REQ-039 adc_valid_in coincident with tick -> sample accepted, miss_out stays 0.

Source files
------------

// File: rtl/sonic_pkg.sv
// Shared definitions for the receiver sample path: ADC/sample widths, the
// framer FSM state type and the ADC-code-to-sample conversion.
package sonic_pkg;

    localparam int unsigned ADC_WIDTH    = 12;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned ADC_MIDSCALE = 2048;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAdc = 2'd1,
        StHold    = 2'd2
    } framer_state_e;

    // Re-centre the unsigned code on midscale and scale by 8 (range -16384..16376).
    function automatic logic signed [SAMPLE_WIDTH-1:0] adc_to_sample(
        input logic [ADC_WIDTH-1:0] code
    );
        logic [SAMPLE_WIDTH-1:0] centered;
        centered = {{(SAMPLE_WIDTH - ADC_WIDTH){1'b0}}, code} - SAMPLE_WIDTH'(ADC_MIDSCALE);
        return signed'(centered << 3);
    endfunction

endpackage

// File: rtl/dc_blocker.sv
// DC tracker and output saturation for accepted ADC samples.
// Build option: define DC_REMOVE_EN to enable the IIR DC tracker; when it is
// undefined the tracked DC is a constant zero and the output equals the input.
module dc_blocker
    import sonic_pkg::*;
#(
    parameter int unsigned DC_SHIFT = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           update_i,
    input  logic signed [SAMPLE_WIDTH-1:0] x_i,
    output logic signed [SAMPLE_WIDTH-1:0] y_o
);

    logic signed [SAMPLE_WIDTH-1:0] dc;
    logic signed [SAMPLE_WIDTH:0]   diff_wide;
    logic signed [SAMPLE_WIDTH-1:0] y_sat;
    logic signed [SAMPLE_WIDTH-1:0] y_q, y_d;

`ifdef DC_REMOVE_EN
    // 24-bit accumulator, 8 fractional bits. The accumulator always stays within
    // the input range, so x*256 - acc fits in 24 signed bits without overflow.
    logic signed [23:0] acc_q, acc_d;
    logic signed [23:0] acc_err;

    assign dc = acc_q[23:8];

    // Leaky integration toward the current sample
    always_comb begin
        acc_err = {x_i, 8'h00} - acc_q;
        acc_d   = acc_q;
        if (update_i) begin
            acc_d = acc_q + (acc_err >>> DC_SHIFT);
        end
    end

    // Accumulator register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign dc = '0;
`endif

    // Subtract the DC estimate held before this sample and clamp to 16 bits
    always_comb begin
        diff_wide = {x_i[SAMPLE_WIDTH-1], x_i} - {dc[SAMPLE_WIDTH-1], dc};
        if (diff_wide[SAMPLE_WIDTH] != diff_wide[SAMPLE_WIDTH-1]) begin
            y_sat = diff_wide[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                                            : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
        end else begin
            y_sat = diff_wide[SAMPLE_WIDTH-1:0];
        end
        y_d = update_i ? y_sat : y_q;
    end

    // Output sample register; holds its value between accepted samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/receiver_sample_framer.sv
// Receiver sample framer: paces ADC conversions at the sample rate, converts and
// DC-corrects results, and groups emitted samples into FRAME_LEN frames.
// Build option: DC_REMOVE_EN enables DC tracking inside dc_blocker.
module receiver_sample_framer
    import sonic_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_RATE_HZ = 200_000,
    parameter int unsigned FRAME_LEN      = 2048,
    parameter int unsigned DC_SHIFT       = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           enable_in,
    output logic                           adc_req_out,
    input  logic [ADC_WIDTH-1:0]           adc_data_in,
    input  logic                           adc_valid_in,
    output logic signed [SAMPLE_WIDTH-1:0] sample_out,
    output logic                           sample_valid_out,
    output logic                           frame_start_out,
    output logic                           frame_done_out,
    output logic                           miss_out
);

    localparam int unsigned TICK_PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int unsigned TickW       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned IdxW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_PERIOD - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(FRAME_LEN - 1);

    logic [1:0]       rst_sync_q;
    logic             ready;
    framer_state_e    state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             sample_valid_q, sample_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             miss_q, miss_d;

    logic tick;
    logic adc_req;
    logic capture;
    logic produce;
    logic miss_set;
    logic last_slot;

    // Reset release synchronizer; the FSM may only tick once this is high
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign ready     = rst_sync_q[1];
    assign tick      = ready && (tick_cnt_q == '0);
    assign last_slot = (idx_q == IdxLast);

    // Sequencing: request on tick, accept one result per request, fill misses.
    // A slot "produces" a sample on capture or when the next tick finds no result.
    always_comb begin
        state_d  = state_q;
        adc_req  = 1'b0;
        capture  = 1'b0;
        produce  = 1'b0;
        miss_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick && enable_in) begin
                    adc_req = 1'b1;
                    state_d = StWaitAdc;
                end
            end
            StWaitAdc: begin
                if (adc_valid_in || tick) begin
                    produce  = 1'b1;
                    capture  = adc_valid_in;
                    miss_set = !adc_valid_in;
                    // Stop only at a frame boundary so no partial frame is emitted
                    if (last_slot && !enable_in) begin
                        state_d = StIdle;
                    end else if (tick) begin
                        adc_req = 1'b1;
                        state_d = StWaitAdc;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    adc_req = 1'b1;
                    state_d = StWaitAdc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Tick counter runs only while framing; parked at zero in idle
    always_comb begin
        if (state_d == StIdle) begin
            tick_cnt_d = '0;
        end else if (tick_cnt_q == TickLast) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end
    end

    // Emission pulses, frame index and sticky miss flag
    always_comb begin
        sample_valid_d = produce;
        frame_start_d  = produce && (idx_q == '0);
        frame_done_d   = produce && last_slot;
        idx_d          = idx_q;
        if (produce) begin
            idx_d = last_slot ? '0 : idx_q + IdxW'(1);
        end
        miss_d = miss_q | miss_set;
    end

    // State and counter registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= StIdle;
            tick_cnt_q     <= '0;
            idx_q          <= '0;
            sample_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            miss_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            idx_q          <= idx_d;
            sample_valid_q <= sample_valid_d;
            frame_start_q  <= frame_start_d;
            frame_done_q   <= frame_done_d;
            miss_q         <= miss_d;
        end
    end

    dc_blocker #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc_blocker (
        .clk_i    (clk_in),
        .rst_ni   (rst_n_in),
        .update_i (capture),
        .x_i      (adc_to_sample(adc_data_in)),
        .y_o      (sample_out)
    );

    assign adc_req_out      = adc_req;
    assign sample_valid_out = sample_valid_q;
    assign frame_start_out  = frame_start_q;
    assign frame_done_out   = frame_done_q;
    assign miss_out         = miss_q;

endmodule
